// File: rtl/omem_potential_store_pkg.sv
// Shared definitions for the output-memory node: geometry, packet layout,
// opcodes, FSM states and a column-pointer helper.
package omem_pkg;

  localparam int NUM_SPE       = 5;
  localparam int OUTPUT_DIM    = 21;
  localparam int SUM_WIDTH     = 13;
  localparam int PKT_W         = 33;
  localparam int NUM_TIMESTEPS = 2;
  localparam int MAP_WRITES    = NUM_SPE * OUTPUT_DIM;

  localparam logic [3:0] OMEM_ID     = 4'd10;
  localparam logic [3:0] SPE_BASE_ID = 4'd0;

  // Packet fields: [32:29] addr, [28:25] opcode, [24:0] data; src in data[24:21]
  localparam int ADDR_W  = 4;
  localparam int OP_W    = 4;
  localparam int PDATA_W = 25;
  localparam int SRC_MSB = 24;
  localparam int SRC_LSB = 21;

  localparam int ROW_W = 3;
  localparam int COL_W = 5;
  localparam int CNT_W = 7;
  localparam int TS_W  = 2;

  localparam logic [3:0] OP_PARTIAL_SUM         = 4'd0;
  localparam logic [3:0] OP_FIRST_TIMESTEP_DONE = 4'd1;
  localparam logic [3:0] OP_PREVIOUS_POTENTIAL  = 4'd2;
  localparam logic [3:0] OP_WRITEBACK_MSB       = 4'b1000;
  // Inbound request shares the encoding of the outbound broadcast opcode
  localparam logic [3:0] OP_PREV_REQUEST        = 4'd1;

  typedef enum logic [1:0] {IDLE, RESP, BCAST} omem_state_e;

  typedef struct packed {
    logic [ADDR_W-1:0]  addr;
    logic [OP_W-1:0]    opcode;
    logic [PDATA_W-1:0] data;
  } pkt_t;

  function automatic logic [COL_W-1:0] col_inc(input logic [COL_W-1:0] c);
    return (c == COL_W'(OUTPUT_DIM - 1)) ? '0 : c + 1'b1;
  endfunction

endpackage

// File: rtl/omem_potential_store_pkt_decode.sv
// Combinational inbound packet decoder.
// Ports: pkt (raw packet), ts_zero (current timestep is 0), stores_closed
// (run complete, no more stores accepted) -> do_store / do_req (legal
// actions), bad (protocol error for a packet addressed to this node),
// row / value / spike (target row and payload for a store or request).
module omem_pkt_decode
  import omem_pkg::*;
(
  input  logic [PKT_W-1:0]     pkt,
  input  logic                 ts_zero,
  input  logic                 stores_closed,
  output logic                 do_store,
  output logic                 do_req,
  output logic                 bad,
  output logic [ROW_W-1:0]     row,
  output logic [SUM_WIDTH-1:0] value,
  output logic                 spike
);

  pkt_t       p;
  logic [3:0] src;
  logic [2:0] k;
  logic       src_ok;
  logic       k_ok;
  logic       unused_bits;

  assign unused_bits = ^p.data[20:14];

  always_comb begin
    p        = pkt_t'(pkt);
    src      = p.data[SRC_MSB:SRC_LSB];
    k        = p.opcode[2:0];
    src_ok   = (src < 4'(NUM_SPE));
    k_ok     = (k < 3'(NUM_SPE));
    do_store = 1'b0;
    do_req   = 1'b0;
    bad      = 1'b0;
    row      = '0;
    value    = '0;
    spike    = 1'b0;
    // Packets for other addresses are silently ignored
    if (p.addr == OMEM_ID) begin
      if ((p.opcode & OP_WRITEBACK_MSB) != 4'd0) begin
        if (k_ok && !ts_zero && !stores_closed) begin
          do_store = 1'b1;
          row      = k;
          value    = p.data[13:1];
          spike    = p.data[0];
        end else begin
          bad = 1'b1;
        end
      end else if (p.opcode == OP_PARTIAL_SUM) begin
        if (src_ok && ts_zero && !stores_closed) begin
          do_store = 1'b1;
          row      = src[ROW_W-1:0];
          value    = p.data[SUM_WIDTH-1:0];
        end else begin
          bad = 1'b1;
        end
      end else if (p.opcode == OP_PREV_REQUEST) begin
        if (src_ok) begin
          do_req = 1'b1;
          row    = src[ROW_W-1:0];
        end else begin
          bad = 1'b1;
        end
      end else begin
        bad = 1'b1;
      end
    end
  end

endmodule

// File: rtl/omem_potential_store.sv
// Output-memory node: stores per-SPE membrane potentials and spikes, answers
// previous-potential requests, broadcasts "first timestep done" to every SPE
// and flags run completion.
// Ports: clk, rst_n (async active-low); in_valid/in_ready/in_pkt inbound
// stream; out_valid/out_ready/out_pkt outbound stream; spk_row/spk_bits
// registered spike-row read; run_done and err sticky status flags.
module omem_potential_store
  import omem_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [PKT_W-1:0]      in_pkt,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [PKT_W-1:0]      out_pkt,
  input  logic [2:0]            spk_row,
  output logic [OUTPUT_DIM-1:0] spk_bits,
  output logic                  run_done,
  output logic                  err
);

  omem_state_e           state, state_nxt;
  logic [SUM_WIDTH-1:0]  pot  [NUM_SPE][OUTPUT_DIM];
  logic [OUTPUT_DIM-1:0] spk  [NUM_SPE];
  logic [COL_W-1:0]      wptr [NUM_SPE];
  logic [COL_W-1:0]      rptr [NUM_SPE];
  logic [CNT_W-1:0]      wr_cnt;
  logic [TS_W-1:0]       ts;
  logic [ROW_W-1:0]      bcnt;
  logic                  bcast_pend;
  logic [ADDR_W-1:0]     resp_addr;
  logic [SUM_WIDTH-1:0]  resp_data;

  logic                  accept, wr_en, map_done, ts0_done, out_fire;
  logic                  do_store, do_req, bad, spike;
  logic [ROW_W-1:0]      row;
  logic [SUM_WIDTH-1:0]  value;

  omem_pkt_decode u_decode (
    .pkt          (in_pkt),
    .ts_zero      (ts == '0),
    .stores_closed(run_done),
    .do_store     (do_store),
    .do_req       (do_req),
    .bad          (bad),
    .row          (row),
    .value        (value),
    .spike        (spike)
  );

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == RESP) || (state == BCAST);
  assign accept    = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;
  assign wr_en     = accept && do_store;
  assign map_done  = wr_en && (wr_cnt == CNT_W'(MAP_WRITES - 1));
  assign ts0_done  = map_done && (ts == '0);

  always_comb begin
    state_nxt = state;
    out_pkt   = '0;
    case (state)
      IDLE: begin
        if (accept && do_req)  state_nxt = RESP;
        else if (ts0_done)     state_nxt = BCAST;
      end
      RESP: begin
        out_pkt = {resp_addr, OP_PREVIOUS_POTENTIAL, {(PDATA_W-SUM_WIDTH){1'b0}}, resp_data};
        if (out_ready) state_nxt = bcast_pend ? BCAST : IDLE;
      end
      BCAST: begin
        out_pkt = {SPE_BASE_ID + 4'(bcnt), OP_FIRST_TIMESTEP_DONE, {PDATA_W{1'b0}}};
        if (out_ready && (bcnt == ROW_W'(NUM_SPE - 1))) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Control stage: FSM, pointers, counters, response capture, status
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      wr_cnt     <= '0;
      ts         <= '0;
      bcnt       <= '0;
      bcast_pend <= 1'b0;
      resp_addr  <= '0;
      resp_data  <= '0;
      run_done   <= 1'b0;
      err        <= 1'b0;
      spk_bits   <= '0;
      for (int r = 0; r < NUM_SPE; r++) begin
        wptr[r] <= '0;
        rptr[r] <= '0;
      end
    end else begin
      state <= state_nxt;
      if (accept && bad) err <= 1'b1;
      if (wr_en) begin
        wptr[row] <= col_inc(wptr[row]);
        wr_cnt    <= map_done ? '0 : wr_cnt + 1'b1;
      end
      if (map_done) begin
        ts <= ts + 1'b1;
        if (ts == TS_W'(NUM_TIMESTEPS - 1)) run_done <= 1'b1;
      end
      // Remember a pending broadcast so a response in flight is finished first
      if (ts0_done)
        bcast_pend <= 1'b1;
      else if ((state == BCAST) && (state_nxt == IDLE))
        bcast_pend <= 1'b0;
      if (accept && do_req) begin
        resp_addr <= SPE_BASE_ID + 4'(row);
        resp_data <= pot[row][rptr[row]];
        rptr[row] <= col_inc(rptr[row]);
      end
      if ((state == BCAST) && out_fire)
        bcnt <= (bcnt == ROW_W'(NUM_SPE - 1)) ? '0 : bcnt + 1'b1;
      spk_bits <= (spk_row < 3'(NUM_SPE)) ? spk[spk_row] : '0;
    end
  end

  // Storage stage: potential and spike arrays
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NUM_SPE; r++) begin
        spk[r] <= '0;
        for (int c = 0; c < OUTPUT_DIM; c++) pot[r][c] <= '0;
      end
    end else if (wr_en) begin
      pot[row][wptr[row]] <= value;
      spk[row][wptr[row]] <= spike;
    end
  end

endmodule
